toplevel: RTL and testbench
===========================

// Module: toplevel
// PURPOSE
//   Board-level wrapper around a small signed ALU, driven from switches and buttons.
//   Switches carry either an operand or an opcode.
//   Three buttons latch the switch value into register A, register B or the opcode register.
//   LEDs show the ALU result of A op B. Single clock domain; top of the design hierarchy.
// PARAMETERS
//   NB_OP   6  width of switch bus and opcode register
//   NB_BTN  3  number of push buttons
//   NB_AB   4  operand / result width (two's complement)
// PORTS
//   clock    in   1       system clock, rising-edge active
//   i_reset  in   1       asynchronous, active-high reset
//   i_sw     in   NB_OP   switches: operand in [NB_AB-1:0], or full opcode
//   i_btn    in   NB_BTN  [0]=load A, [1]=load B, [2]=load opcode
//   o_led    out  NB_AB   ALU result, signed
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-high.
//   Reset: A, B and opcode registers are set to 0. Opcode 0 is unmapped, so o_led = 0.
//   Register loads, on each rising clock edge:
//     i_btn[0]=1 -> A  <= i_sw[NB_AB-1:0]; upper switch bits are ignored.
//     i_btn[1]=1 -> B  <= i_sw[NB_AB-1:0]
//     i_btn[2]=1 -> OP <= i_sw[NB_OP-1:0]
//   Buttons are level-sensitive and independent of each other.
//   If several buttons are high together, all selected registers load the same switch value.
//   A button held high reloads its register on every edge. No edge detection or debounce.
//   With no button pressed, all registers hold their value.
//   ALU is combinational from A, B, OP. o_led updates in the same cycle as any register change.
//   Net latency: o_led is valid right after the first rising edge with a load button high.
//   Opcodes (OP):
//     100000 ADD : A+B, NB_AB bits, wraps modulo 2^NB_AB, no overflow flag
//     100010 SUB : A-B, wraps
//     100100 AND : A&B
//     100101 OR  : A|B
//     100110 XOR : A^B
//     000011 SRA : A>>>B, arithmetic, sign-filled
//     000010 SRL : A>>B, logical, zero-filled
//     100111 NOR : ~(A|B)
//     any other  : o_led = 0
//   Shifts: B is an unsigned shift amount (0..2^NB_AB-1).
//     Shift amount >= NB_AB: SRA gives all sign bits; SRL gives 0.
//   Reset mid-operation: registers clear immediately (asynchronous). Loads resume on the first edge after release.
// TESTING
//   Reset asserted -> o_led=0000; after release with no buttons pressed, o_led stays 0000.
//   A=0101, B=0011 via btn 001/010, then each opcode with btn 100 ->
//     ADD 1000, SUB 0010, AND 0001, OR 0111, XOR 0110, NOR 1000.
//   Wrap-around: A=0111, B=0001, ADD -> 1000. A=1000, B=0001, SUB -> 0111.
//   Shifts with A=1000:
//     B=0001: SRA -> 1100, SRL -> 0100.
//     B=0110: SRA -> 1111, SRL -> 0000.
//   Unmapped opcode 111111 with any A/B -> 0000.
//     Change A with OP=ADD held -> o_led follows the new A+B after one edge.
//   Random regression: 20 random A/B pairs x all 8 opcodes; compare o_led to a 4-bit signed reference model.
//     Also drive i_sw upper bits nonzero during operand loads -> upper bits ignored.

Source files
------------

// File: rtl/toplevel.sv
// Board-level wrapper around a small signed ALU.
// Switches supply either an operand or an opcode; three push buttons latch
// the switch value into operand A, operand B or the opcode register, and
// the LEDs continuously show A op B.

module toplevel #(
   parameter int NB_OP  = 6,
   parameter int NB_BTN = 3,
   parameter int NB_AB  = 4
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic [NB_OP-1:0]  i_sw,
   input  logic [NB_BTN-1:0] i_btn,
   output logic [NB_AB-1:0]  o_led
);

   // Opcode encodings understood by the ALU; everything else shows zero.
   localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
   localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
   localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
   localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
   localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
   localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
   localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;
   localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;

   logic [NB_AB-1:0] regA_q, regA_d;
   logic [NB_AB-1:0] regB_q, regB_d;
   logic [NB_OP-1:0] opcode_q, opcode_d;
   logic [NB_AB-1:0] aluResult;

   // Each button independently selects whether its register takes the
   // switches this cycle; several buttons may load the same value at once.
   always_comb begin
      regA_d   = regA_q;
      regB_d   = regB_q;
      opcode_d = opcode_q;
      if (i_btn[0]) begin
         regA_d = i_sw[NB_AB-1:0];
      end
      if (i_btn[1]) begin
         regB_d = i_sw[NB_AB-1:0];
      end
      if (i_btn[2]) begin
         opcode_d = i_sw[NB_OP-1:0];
      end
   end

   // Operand and opcode registers; reset clears them immediately, which
   // leaves the unmapped opcode 0 selected so the LEDs read zero.
   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         regA_q   <= '0;
         regB_q   <= '0;
         opcode_q <= '0;
      end else begin
         regA_q   <= regA_d;
         regB_q   <= regB_d;
         opcode_q <= opcode_d;
      end
   end

   // Purely combinational ALU. Arithmetic wraps at the operand width.
   // B is an unsigned shift amount; shifting by NB_AB or more naturally
   // yields all sign bits (arithmetic) or all zeros (logical).
   always_comb begin
      aluResult = '0;
      case (opcode_q)
         OP_ADD:  aluResult = regA_q + regB_q;
         OP_SUB:  aluResult = regA_q - regB_q;
         OP_AND:  aluResult = regA_q & regB_q;
         OP_OR:   aluResult = regA_q | regB_q;
         OP_XOR:  aluResult = regA_q ^ regB_q;
         OP_SRA:  aluResult = $unsigned($signed(regA_q) >>> regB_q);
         OP_SRL:  aluResult = regA_q >> regB_q;
         OP_NOR:  aluResult = ~(regA_q | regB_q);
         default: aluResult = '0;
      endcase
   end

   assign o_led = aluResult;

endmodule

// File: tb/tb_toplevel.sv
// Self-checking bench for the switch/button ALU wrapper.
// A simple integer model tracks what each register should hold and
// computes the expected LED value from the opcode rules directly.

module tb_toplevel;

   localparam int NB_OP  = 6;
   localparam int NB_BTN = 3;
   localparam int NB_AB  = 4;

   logic              clock = 1'b0;
   logic              i_reset;
   logic [NB_OP-1:0]  i_sw;
   logic [NB_BTN-1:0] i_btn;
   logic [NB_AB-1:0]  o_led;

   int checkCount = 0;
   int errorCount = 0;

   int modelA  = 0;
   int modelB  = 0;
   int modelOp = 0;

   int opList[8] = '{32, 34, 36, 37, 38, 3, 2, 39};

   toplevel #(.NB_OP(NB_OP), .NB_BTN(NB_BTN), .NB_AB(NB_AB)) dut (
      .clock   (clock),
      .i_reset (i_reset),
      .i_sw    (i_sw),
      .i_btn   (i_btn),
      .o_led   (o_led)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   // Single point through which every comparison passes.
   task automatic checkOutput(input string tag, input logic [NB_AB-1:0] observed,
                              input logic [NB_AB-1:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %b, expected %b", tag, observed, expected);
      end
   endtask

   // Expected LED value from 4-bit two's-complement operand semantics.
   function automatic logic [NB_AB-1:0] aluRef(input int a, input int b, input int op);
      int signedA;
      int r;
      logic [31:0] bits;
      signedA = (a >= 8) ? a - 16 : a;
      case (op)
         32:      r = a + b;
         34:      r = a - b;
         36:      r = a & b;
         37:      r = a | b;
         38:      r = a ^ b;
         3:       r = signedA >>> b;
         2:       r = a >> b;
         39:      r = ~(a | b);
         default: r = 0;
      endcase
      bits = r & 15;
      return bits[NB_AB-1:0];
   endfunction

   // Present the switches with the given buttons for exactly one rising
   // edge, then release the buttons and update the register model.
   task automatic applyStimulus(input logic [NB_OP-1:0] sw, input logic [NB_BTN-1:0] btn);
      @(negedge clock);
      i_sw  = sw;
      i_btn = btn;
      @(negedge clock);
      i_btn = '0;
      if (btn[0]) modelA  = int'(sw[NB_AB-1:0]);
      if (btn[1]) modelB  = int'(sw[NB_AB-1:0]);
      if (btn[2]) modelOp = int'(sw);
   endtask

   task automatic loadOperands(input int a, input int b);
      logic [NB_OP-1:0] sw;
      sw = {2'($urandom_range(0, 3)), 4'(a)};
      applyStimulus(sw, 3'b001);
      sw = {2'($urandom_range(0, 3)), 4'(b)};
      applyStimulus(sw, 3'b010);
   endtask

   task automatic checkModel(input string tag);
      checkOutput(tag, o_led, aluRef(modelA, modelB, modelOp));
   endtask

   initial begin
      i_reset = 1'b1;
      i_sw    = '0;
      i_btn   = '0;

      // Reset state
      #12;
      checkOutput("reset_active", o_led, 4'b0000);
      @(negedge clock);
      i_reset = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("idle_after_reset", o_led, 4'b0000);

      // Directed opcodes with A=0101, B=0011
      applyStimulus(6'b000101, 3'b001);
      applyStimulus(6'b000011, 3'b010);
      applyStimulus(6'b100000, 3'b100); checkOutput("add_5_3", o_led, 4'b1000);
      applyStimulus(6'b100010, 3'b100); checkOutput("sub_5_3", o_led, 4'b0010);
      applyStimulus(6'b100100, 3'b100); checkOutput("and_5_3", o_led, 4'b0001);
      applyStimulus(6'b100101, 3'b100); checkOutput("or_5_3",  o_led, 4'b0111);
      applyStimulus(6'b100110, 3'b100); checkOutput("xor_5_3", o_led, 4'b0110);
      applyStimulus(6'b100111, 3'b100); checkOutput("nor_5_3", o_led, 4'b1000);

      // Wrap-around
      applyStimulus(6'b000111, 3'b001);
      applyStimulus(6'b000001, 3'b010);
      applyStimulus(6'b100000, 3'b100); checkOutput("add_wrap", o_led, 4'b1000);
      applyStimulus(6'b001000, 3'b001);
      applyStimulus(6'b100010, 3'b100); checkOutput("sub_wrap", o_led, 4'b0111);

      // Shifts with A=1000
      applyStimulus(6'b000011, 3'b100); checkOutput("sra_by1", o_led, 4'b1100);
      applyStimulus(6'b000010, 3'b100); checkOutput("srl_by1", o_led, 4'b0100);
      applyStimulus(6'b000110, 3'b010);
      checkOutput("srl_by6", o_led, 4'b0000);
      applyStimulus(6'b000011, 3'b100); checkOutput("sra_by6", o_led, 4'b1111);

      // Unmapped opcode
      applyStimulus(6'b111111, 3'b100); checkOutput("unmapped_op", o_led, 4'b0000);

      // Change A with ADD held, upper switch bits set during the load
      applyStimulus(6'b100000, 3'b100);
      applyStimulus(6'b110010, 3'b001);
      checkOutput("add_follow_a", o_led, 4'b1000);

      // Several buttons at once load the same value everywhere
      applyStimulus(6'b100100, 3'b111);
      checkOutput("multi_button", o_led, 4'b0100);

      // Held button reloads on every edge
      @(negedge clock);
      i_sw  = 6'b100101;
      i_btn = 3'b100;
      @(negedge clock);
      i_sw  = 6'b100110;
      @(negedge clock);
      i_btn = '0;
      modelOp = 38;
      checkOutput("held_reload", o_led, 4'b0000);

      // Asynchronous reset in the middle of operation
      applyStimulus(6'b000101, 3'b001);
      applyStimulus(6'b000011, 3'b010);
      applyStimulus(6'b100000, 3'b100);
      checkOutput("pre_reset_add", o_led, 4'b1000);
      #2;
      i_reset = 1'b1;
      #1;
      checkOutput("async_reset_clear", o_led, 4'b0000);
      modelA = 0; modelB = 0; modelOp = 0;
      @(negedge clock);
      i_reset = 1'b0;
      @(negedge clock);
      checkOutput("post_reset_hold", o_led, 4'b0000);
      applyStimulus(6'b000110, 3'b001);
      applyStimulus(6'b000001, 3'b010);
      applyStimulus(6'b100000, 3'b100);
      checkOutput("post_reset_load", o_led, 4'b0111);

      // Random regression against the reference model
      for (int pairIdx = 0; pairIdx < 20; pairIdx++) begin
         int a;
         int b;
         a = int'($urandom_range(0, 15));
         b = int'($urandom_range(0, 15));
         loadOperands(a, b);
         for (int opIdx = 0; opIdx < 8; opIdx++) begin
            applyStimulus(6'(opList[opIdx]), 3'b100);
            checkModel($sformatf("rand_a%0d_b%0d_op%0d", a, b, opList[opIdx]));
         end
         applyStimulus(6'($urandom_range(0, 63)), 3'b100);
         checkModel($sformatf("rand_a%0d_b%0d_opx%0d", a, b, modelOp));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
